// File: rtl/fft_pkg.sv
// Shared constants for the FFT front-end: sample width, FSM state
// encodings and the bit-reversal helper used for output ordering.
package fft_pkg;

    localparam int CPLX_W    = 16;
    localparam int MAX_LOG2N = 12;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RUN  = 1'b1;

    // Reverse the low log2n bits of value; bits above log2n must be zero.
    function automatic logic [MAX_LOG2N-1:0] bit_reverse(
        input logic [MAX_LOG2N-1:0] value,
        input int                   log2n
    );
        logic [MAX_LOG2N-1:0] full_rev;
        full_rev = '0;
        for (int i = 0; i < MAX_LOG2N; i++) begin
            full_rev[i] = value[MAX_LOG2N-1-i];
        end
        return full_rev >> (MAX_LOG2N - log2n);
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port RAM holding both ping-pong banks; the address MSB picks
// the bank. Synchronous write, registered read with one cycle of latency.
module fft_pingpong_ram
    import fft_pkg::*;
#(
    parameter int AW = 9,
    parameter int W  = 2 * CPLX_W
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [2**AW];

    // Write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong reorder buffer: collects N-sample complex frames and replays each
// completed frame as a gap-free burst in natural or bit-reversed order, with
// the frame's inverse-transform flag aligned to its burst.
module fft_bitrev_buffer
    import fft_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int DW    = CPLX_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
    input  logic          sop_in,
    input  logic          inv_in,
    input  logic          bitrev_en,
    input  logic [DW-1:0] x_re,
    input  logic [DW-1:0] x_im,
    output logic          valid_out,
    output logic          sop_out,
    output logic          eop_out,
    output logic          inv_out,
    output logic [DW-1:0] y_re,
    output logic [DW-1:0] y_im,
    output logic          frame_err
);

    localparam int               AW   = LOG2N + 1;
    localparam logic [LOG2N-1:0] LAST = LOG2N'((1 << LOG2N) - 1);

    // Write side state
    logic [0:0]       w_state_reg;
    logic [LOG2N-1:0] wr_cnt_reg;
    logic             wr_bank_reg;
    logic             wr_inv_reg;
    logic             wr_rev_reg;

    // Per-bank status
    logic [1:0] full_reg;
    logic [1:0] inv_bank_reg;
    logic [1:0] rev_bank_reg;
    logic [1:0] bank_set;
    logic [1:0] bank_clr;

    // Read side state
    logic [0:0]       r_state_reg;
    logic [LOG2N-1:0] rd_cnt_reg;
    logic             rd_bank_reg;

    // Read pipeline stage aligned with the RAM output
    logic s1_valid_reg;
    logic s1_sop_reg;
    logic s1_eop_reg;
    logic s1_inv_reg;

    // Combinational control
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr_lo;
    logic             wr_done;
    logic             wr_restart;
    logic             err_next;
    logic             rd_active;
    logic             rd_last;
    logic             other_ready;
    logic [LOG2N-1:0] cur_cnt;
    logic [LOG2N-1:0] rd_addr_lo;
    logic [2*DW-1:0]  rd_data;

    // Write-side decode: sop always (re)starts a frame at index 0; a sop
    // inside an open frame or a stray sample while idle is a framing error.
    always_comb begin
        wr_en      = 1'b0;
        wr_addr_lo = '0;
        wr_done    = 1'b0;
        wr_restart = 1'b0;
        err_next   = 1'b0;
        if (valid_in) begin
            if (sop_in) begin
                wr_en      = 1'b1;
                wr_restart = 1'b1;
                err_next   = (w_state_reg == W_FILL);
            end else if (w_state_reg == W_IDLE) begin
                err_next = 1'b1;
            end else begin
                wr_en      = 1'b1;
                wr_addr_lo = wr_cnt_reg;
                wr_done    = (wr_cnt_reg == LAST);
            end
        end
    end

    // Write FSM, sample counter, bank toggle and per-frame flag latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
            wr_cnt_reg  <= '0;
            wr_bank_reg <= 1'b0;
            wr_inv_reg  <= 1'b0;
            wr_rev_reg  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= err_next;
            if (wr_restart) begin
                w_state_reg <= W_FILL;
                wr_cnt_reg  <= LOG2N'(1);
                wr_inv_reg  <= inv_in;
                wr_rev_reg  <= bitrev_en;
            end else if (wr_done) begin
                w_state_reg <= W_IDLE;
                wr_cnt_reg  <= '0;
                wr_bank_reg <= ~wr_bank_reg;
            end else if (wr_en) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end
        end
    end

    // Read-side decode: in R_IDLE the first address is issued in the same
    // cycle the bank is seen full, which gives the two-cycle latency.
    // A bank completing on the very edge the current burst ends counts as
    // ready so back-to-back bursts have no idle cycle.
    always_comb begin
        rd_active   = (r_state_reg == R_RUN) || full_reg[rd_bank_reg];
        cur_cnt     = (r_state_reg == R_RUN) ? rd_cnt_reg : '0;
        rd_last     = rd_active && (cur_cnt == LAST);
        other_ready = full_reg[~rd_bank_reg] || (wr_done && (wr_bank_reg != rd_bank_reg));
        rd_addr_lo  = rev_bank_reg[rd_bank_reg]
                    ? LOG2N'(bit_reverse(MAX_LOG2N'(cur_cnt), LOG2N))
                    : cur_cnt;
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_set[gi] = wr_done && (wr_bank_reg == 1'(gi));
            assign bank_clr[gi] = rd_last && (rd_bank_reg == 1'(gi));
        end
    endgenerate

    // Bank full flags and the flags captured with each completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg     <= '0;
            inv_bank_reg <= '0;
            rev_bank_reg <= '0;
        end else begin
            full_reg     <= (full_reg & ~bank_clr) | bank_set;
            inv_bank_reg <= (inv_bank_reg & ~bank_set) | (bank_set & {2{wr_inv_reg}});
            rev_bank_reg <= (rev_bank_reg & ~bank_set) | (bank_set & {2{wr_rev_reg}});
        end
    end

    // Read FSM: N consecutive reads per bank, chaining into the other bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
            rd_cnt_reg  <= '0;
            rd_bank_reg <= 1'b0;
        end else if (rd_active) begin
            if (rd_last) begin
                rd_cnt_reg  <= '0;
                rd_bank_reg <= ~rd_bank_reg;
                r_state_reg <= other_ready ? R_RUN : R_IDLE;
            end else begin
                rd_cnt_reg  <= cur_cnt + 1'b1;
                r_state_reg <= R_RUN;
            end
        end
    end

    fft_pingpong_ram #(
        .AW (AW),
        .W  (2 * DW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr ({wr_bank_reg, wr_addr_lo}),
        .wr_data ({x_re, x_im}),
        .rd_en   (rd_active),
        .rd_addr ({rd_bank_reg, rd_addr_lo}),
        .rd_data (rd_data)
    );

    // Framing flags delayed to line up with the registered RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sop_reg   <= 1'b0;
            s1_eop_reg   <= 1'b0;
            s1_inv_reg   <= 1'b0;
        end else begin
            s1_valid_reg <= rd_active;
            s1_sop_reg   <= rd_active && (cur_cnt == '0);
            s1_eop_reg   <= rd_last;
            s1_inv_reg   <= inv_bank_reg[rd_bank_reg];
        end
    end

    // Output register; inv_out only updates at the start of a burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
            inv_out   <= 1'b0;
            y_re      <= '0;
            y_im      <= '0;
        end else begin
            valid_out <= s1_valid_reg;
            sop_out   <= s1_sop_reg;
            eop_out   <= s1_eop_reg;
            if (s1_sop_reg) begin
                inv_out <= s1_inv_reg;
            end
            y_re <= s1_valid_reg ? rd_data[2*DW-1:DW] : '0;
            y_im <= s1_valid_reg ? rd_data[DW-1:0]    : '0;
        end
    end

endmodule

// File: doc/fft_bitrev_buffer.md
Name: fft_bitrev_buffer

Overview:
Parametrised ping-pong reorder buffer that sits in front of the FFT butterfly pipeline. It collects complex frames of N = 2^LOG2N samples framed by sop_in/valid_in and replays each completed frame as a contiguous burst. The burst is in bit-reversed or natural order, selected per frame. Each frame's inverse-transform flag is carried alongside it so downstream butterfly stages see mode and data aligned.

Parameters:
LOG2N, 8, log2 of frame length; legal range 2..12 (N = 4..4096).
DW, 16, width of each real/imag component, two's complement.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
valid_in  in  1  input sample qualifier.
sop_in  in  1  first sample of a frame; meaningful only with valid_in=1.
inv_in  in  1  inverse-FFT flag; sampled with sop_in.
bitrev_en  in  1  1 = bit-reversed output order, 0 = natural order; sampled with sop_in.
x_re  in  DW  input real part.
x_im  in  DW  input imaginary part.
valid_out  out  1  output sample qualifier.
sop_out  out  1  first output sample of a frame.
eop_out  out  1  last output sample of a frame.
inv_out  out  1  latched inv_in of the frame being output; held for all N cycles.
y_re  out  DW  output real part.
y_im  out  DW  output imaginary part.
frame_err  out  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - all outputs go to 0;
  - write/read counters clear and both banks are marked empty;
  - any partial or pending frame is discarded;
  - RAM contents are not cleared.
- Write side FSM, states W_IDLE and W_FILL:
  - W_IDLE: valid_in & sop_in writes sample 0 into the current write bank, latches inv_in/bitrev_en, and moves to W_FILL with wr_cnt=1.
  - W_IDLE: valid_in without sop_in drops the sample and pulses frame_err.
  - W_FILL: each valid_in writes address wr_cnt, then wr_cnt increments. valid_in=0 cycles are gaps and are allowed.
  - W_FILL: when sample N-1 is written, the bank is marked full with its latched flags, the write bank toggles, and the FSM returns to W_IDLE.
  - W_FILL: valid_in & sop_in before sample N-1 pulses frame_err, discards the partial frame, and restarts at index 0 in the same bank with newly latched flags.
- Read side FSM, states R_IDLE and R_RUN:
  - R_IDLE to R_RUN when a full bank exists. Read address = rd_cnt, or bit_reverse(rd_cnt) if that frame's bitrev_en=1.
  - R_RUN streams exactly N consecutive cycles with no gaps and no backpressure. The bank is freed after address N-1 is issued.
  - If the other bank is already full at that point, the next burst follows with zero idle cycles. Otherwise return to R_IDLE.
- Latency: the last input sample is captured at edge k; sop_out=valid_out=1 with output index 0 from edge k+2 (registered RAM read plus output register).
- sop_out is high with output index 0 only; eop_out is high with index N-1 only. For N>=4 they are never coincident.
- Throughput: ping-pong guarantees no overflow at 100% input duty. Burst of frame F ends no later than frame F+1 completes, so no overflow flag is needed.
- Data passes through unmodified: no scaling, no rounding.
- inv_out changes only on the cycle of sop_out.

Decomposition:
- Shared package fft_pkg holds:
  - function bit_reverse(value, LOG2N), generalising the 8-bit reverse;
  - a complex-sample width constant with default 16;
  - FSM state encodings W_IDLE/W_FILL/R_IDLE/R_RUN.
- One sub-module: fft_pingpong_ram, a simple dual-port RAM of 2N x 2DW.
  - Address MSB selects the bank.
  - Synchronous write; registered synchronous read with 1-cycle latency.
  - The top module holds both FSMs, counters, bank-full flags, the flag pipeline and the output register.

Test Plan:
1. Bit-reversed ramp. LOG2N=8, bitrev_en=1, one frame x_re=k, x_im=-k for k=0..255 -> sop_out 2 cycles after last input. Outputs y_re = 0,128,64,192,...,255; y_im = negation; eop_out on 256th output.
2. Natural order. Same frame with bitrev_en=0 -> y_re = 0,1,...,255 in order; exactly 256 valid_out cycles.
3. Back-to-back frames. Frame A ramp, frame B = ramp+1000, no idle input cycles -> 512 contiguous valid_out cycles. B's sop_out immediately follows A's eop_out; frame_err never asserts.
4. Mid-frame sop. sop_in reasserted at sample 100 -> frame_err high exactly 1 cycle; no output for the aborted frame. The following complete frame is output correctly.
5. Gaps and reset.
   - valid_in at 50% duty -> output ordering identical to test 1.
   - Separately, rst=1 at input sample 50 -> all outputs 0 from the next cycle; no burst ever emitted for that frame.
   - Stray valid_in without sop_in in W_IDLE -> frame_err pulse, sample dropped.
6. Small frame and inv flag. LOG2N=3, bitrev_en=1, inv_in=1, ramp 0..7 -> y_re = 0,4,2,6,1,5,3,7 and inv_out=1 for all 8 output cycles. Next frame with inv_in=0 -> inv_out drops at its sop_out.
